// File: rtl/mem_dbus_pkg.sv
// Shared constants and lane helpers for the MEM-stage data-bus block.
// Opcodes and stall/write constants mirror the core-wide definitions.
package mem_dbus_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS   = 8;

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;

  // Big-endian: offset 0 is the most significant byte of the word.
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      2'b11:   b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] get_half(input logic [31:0] word, input logic low_half);
    logic [15:0] h;
    if (low_half) begin
      h = word[15:0];
    end else begin
      h = word[31:16];
    end
    return h;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store replication, load
// extraction/extension and misalignment detection for one access.
module mem_align
  import mem_dbus_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        is_mem,
  output logic        is_load,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selected from the returned bus word
  always_comb begin
    byte_s = get_byte(rdata, addr_lo);
    half_s = get_half(rdata, addr_lo[1]);
  end

  // Per-opcode decode of enables, data shaping and alignment
  always_comb begin
    sel      = 4'b0000;
    st_data  = 32'h0000_0000;
    ld_data  = 32'h0000_0000;
    is_mem   = 1'b0;
    is_load  = 1'b0;
    misalign = 1'b0;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
        sel     = 4'b1000 >> addr_lo;
        if (aluop == EXE_LB_OP) begin
          ld_data = {{24{byte_s[7]}}, byte_s};
        end else begin
          ld_data = {24'h00_0000, byte_s};
        end
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        is_mem   = 1'b1;
        is_load  = 1'b1;
        misalign = addr_lo[0];
        sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
        if (aluop == EXE_LH_OP) begin
          ld_data = {{16{half_s[15]}}, half_s};
        end else begin
          ld_data = {16'h0000, half_s};
        end
      end
      EXE_LW_OP: begin
        is_mem   = 1'b1;
        is_load  = 1'b1;
        misalign = (addr_lo != 2'b00);
        sel      = 4'b1111;
        ld_data  = rdata;
      end
      EXE_SB_OP: begin
        is_mem  = 1'b1;
        sel     = 4'b1000 >> addr_lo;
        st_data = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        is_mem   = 1'b1;
        misalign = addr_lo[0];
        sel      = addr_lo[1] ? 4'b0011 : 4'b1100;
        st_data  = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        is_mem   = 1'b1;
        misalign = (addr_lo != 2'b00);
        sel      = 4'b1111;
        st_data  = reg2;
      end
      default: begin
        is_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_dbus.sv
// MEM stage: runs handshaked load/store accesses, holds the pipeline
// until each completes, then forwards writeback fields to MEM/WB.
module mem_dbus
  import mem_dbus_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic                    flush,
  input  logic [REG_ADDR_BUS-1:0] wd_i,
  input  logic                    wreg_i,
  input  logic [REG_BUS-1:0]      wdata_i,
  input  logic                    whilo_i,
  input  logic [REG_BUS-1:0]      hi_i,
  input  logic [REG_BUS-1:0]      lo_i,
  input  logic [ALU_OP_BUS-1:0]   aluop_i,
  input  logic [REG_BUS-1:0]      mem_addr_i,
  input  logic [REG_BUS-1:0]      reg2_i,
  input  logic                    cp0_we_i,
  input  logic [4:0]              cp0_waddr_i,
  input  logic [REG_BUS-1:0]      cp0_data_i,
  output logic [REG_ADDR_BUS-1:0] wd_o,
  output logic                    wreg_o,
  output logic [REG_BUS-1:0]      wdata_o,
  output logic                    whilo_o,
  output logic [REG_BUS-1:0]      hi_o,
  output logic [REG_BUS-1:0]      lo_o,
  output logic                    cp0_we_o,
  output logic [4:0]              cp0_waddr_o,
  output logic [REG_BUS-1:0]      cp0_data_o,
  output logic                    stallreq,
  output logic                    adel_o,
  output logic                    ades_o,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [REG_BUS-1:0]      dbus_addr,
  output logic [3:0]              dbus_sel,
  output logic [REG_BUS-1:0]      dbus_wdata,
  input  logic                    dbus_ack,
  input  logic [REG_BUS-1:0]      dbus_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] ld_data_r;
  logic [3:0]  sel_s;
  logic [31:0] st_data_s;
  logic [31:0] ld_ext_s;
  logic        is_mem_s;
  logic        is_load_s;
  logic        misalign_s;
  logic        start_s;
  logic        stall_unused_s;

  assign stall_unused_s = ^{stall[5], stall[3:0]};

  mem_align u_align (
    .aluop    (aluop_i),
    .addr_lo  (mem_addr_i[1:0]),
    .reg2     (reg2_i),
    .rdata    (dbus_rdata),
    .sel      (sel_s),
    .st_data  (st_data_s),
    .ld_data  (ld_ext_s),
    .is_mem   (is_mem_s),
    .is_load  (is_load_s),
    .misalign (misalign_s)
  );

  // An access starts only from IDLE with an aligned memory op and no flush
  always_comb begin
    if ((state_r == ST_IDLE) && is_mem_s && !misalign_s && !flush) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = start_s ? ST_BUSY : ST_IDLE;
        ST_BUSY: state_nxt_s = dbus_ack ? ST_DONE : ST_BUSY;
        ST_DONE: state_nxt_s = (stall[4] == NO_STOP) ? ST_IDLE : ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered bus request fields and captured load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0000_0000;
      dbus_sel   <= 4'b0000;
      dbus_wdata <= 32'h0000_0000;
      ld_data_r  <= 32'h0000_0000;
    end else if (flush) begin
      dbus_req <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            dbus_req   <= 1'b1;
            dbus_we    <= ~is_load_s;
            dbus_addr  <= mem_addr_i;
            dbus_sel   <= sel_s;
            dbus_wdata <= is_load_s ? 32'h0000_0000 : st_data_s;
          end
        end
        ST_BUSY: begin
          if (dbus_ack) begin
            dbus_req  <= 1'b0;
            ld_data_r <= ld_ext_s;
          end
        end
        default: begin
          dbus_req <= 1'b0;
        end
      endcase
    end
  end

  // Writeback passthrough, load-result substitution, stall and error flags
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    whilo_o     = whilo_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    cp0_we_o    = cp0_we_i;
    cp0_waddr_o = cp0_waddr_i;
    cp0_data_o  = cp0_data_i;
    stallreq    = 1'b0;
    adel_o      = 1'b0;
    ades_o      = 1'b0;
    if (is_mem_s && misalign_s) begin
      wreg_o = WRITE_DISABLE;
      adel_o = is_load_s;
      ades_o = ~is_load_s;
    end else if (is_mem_s) begin
      case (state_r)
        ST_IDLE: stallreq = start_s;
        ST_BUSY: stallreq = 1'b1;
        ST_DONE: begin
          if (is_load_s) begin
            wdata_o = ld_data_r;
          end else begin
            wdata_o = wdata_i;
          end
        end
        default: stallreq = 1'b0;
      endcase
    end else begin
      stallreq = 1'b0;
    end
  end

endmodule
